pkt_sched: RTL

//  Packet scheduler in front of NUM_PROCS proc instances. Queues incoming packet

---
 rtl/pkt_sched_pkg.sv | 55 +++++
 rtl/sched_fifo.sv | 53 +++++
 rtl/pkt_sched.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/pkt_sched_pkg.sv
// Shared types for the packet scheduler: slot state codes, round-robin pick helpers.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package pkt_sched_pkg;

    localparam int ADDR_W     = 32;
    localparam int MAX_PROCS  = 8;
    localparam int PROC_IDX_W = 3;

    typedef enum logic [2:0] {
        SLOT_IDLE = 3'd0,
        SLOT_ARM  = 3'd1,
        SLOT_RUN  = 3'd2,
        SLOT_DONE = 3'd3,
        SLOT_COOL = 3'd4
    } slot_state_e;

    typedef logic [MAX_PROCS-1:0] proc_mask_t;

    typedef struct packed {
        logic                  vld;
        logic [PROC_IDX_W-1:0] idx;
    } rr_pick_t;

    typedef struct packed {
        logic                  vld;
        logic [ADDR_W-1:0]     addr;
        logic [PROC_IDX_W-1:0] proc;
    } done_rpt_t;

    // First requester at or after ptr, wrapping modulo n. Scanning from the far
    // end lets the smallest offset overwrite any later candidate.
    function automatic rr_pick_t rr_pick(input proc_mask_t req,
                                         input logic [PROC_IDX_W-1:0] ptr,
                                         input int n);
        rr_pick_t              p;
        logic [PROC_IDX_W-1:0] c;
        p = '{vld: 1'b0, idx: '0};
        for (int k = MAX_PROCS - 1; k >= 0; k--) begin
            if (k < n) begin
                c = PROC_IDX_W'((int'(ptr) + k) % n);
                if (req[c]) begin
                    p = '{vld: 1'b1, idx: c};
                end
            end
        end
        return p;
    endfunction

    function automatic logic [PROC_IDX_W-1:0] rr_next(input logic [PROC_IDX_W-1:0] idx,
                                                      input int n);
        return (int'(idx) + 1 >= n) ? '0 : idx + PROC_IDX_W'(1);
    endfunction

endpackage

// File: rtl/sched_fifo.sv
// Packet-address FIFO using wrap-bit read/write pointers (no occupancy counter).
// Latency: a pushed entry is visible at the head from the next cycle.
// Backpressure: pushes while full and pops while empty are ignored.
module sched_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic [W-1:0] push_dat_i,
    input  logic         pop_i,
    output logic [W-1:0] pop_dat_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int          AW      = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic [W-1:0] mem_q [DEPTH];
    logic         do_push, do_pop;

    always_comb begin
        // Same index with differing wrap bits means the writer has lapped the reader.
        full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        empty_o   = (wr_ptr_q == rd_ptr_q);
        do_push   = push_i && !full_o;
        do_pop    = pop_i && !empty_o;
        wr_ptr_d  = do_push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d  = do_pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        pop_dat_o = mem_q[rd_ptr_q[AW-1:0]];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_dat_i;
        end
    end

endmodule

// File: rtl/pkt_sched.sv
// Queues packet addresses and dispatches them round-robin to NUM_PROCS procs; reports completions.
// Latency: dispatch one edge after push at best; done strobe one edge after the slot reaches DONE.
// Backpressure: pkt_ready_o drops when the queue is full; done strobe cannot be stalled.
module pkt_sched
    import pkt_sched_pkg::*;
#(
    parameter int NUM_PROCS   = 2,
    parameter int QUEUE_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        pkt_valid_i,
    input  logic [ADDR_W-1:0]           pkt_addr_i,
    output logic                        pkt_ready_o,
    output logic [NUM_PROCS-1:0]        start_o,
    output logic [NUM_PROCS*ADDR_W-1:0] pkt_addr_o,
    input  logic [NUM_PROCS-1:0]        proc_ready_i,
    output logic                        done_valid_o,
    output logic [ADDR_W-1:0]           done_addr_o,
    output logic [PROC_IDX_W-1:0]       done_proc_o,
    output logic                        busy_o
);

    slot_state_e           slot_q [NUM_PROCS];
    slot_state_e           slot_d [NUM_PROCS];
    logic [ADDR_W-1:0]     addr_q [NUM_PROCS];
    logic [ADDR_W-1:0]     addr_d [NUM_PROCS];
    logic [NUM_PROCS-1:0]  start_q, start_d;
    logic [PROC_IDX_W-1:0] disp_ptr_q, disp_ptr_d;
    logic [PROC_IDX_W-1:0] rep_ptr_q, rep_ptr_d;
    done_rpt_t             done_q, done_d;
    logic                  ready_en_q, ready_en_d;

    logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [ADDR_W-1:0]     fifo_dat;
    proc_mask_t            idle_mask, done_mask;
    rr_pick_t              disp_pick, rep_pick;
    logic                  disp_fire, rep_fire;
    logic                  any_active;

    // Gated by a flop cleared on reset so the loader sees no room while reset is held.
    assign pkt_ready_o = ready_en_q && !fifo_full;
    assign fifo_push   = pkt_valid_i && pkt_ready_o;
    assign fifo_pop    = disp_fire;

    sched_fifo #(
        .DEPTH (QUEUE_DEPTH),
        .W     (ADDR_W)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (fifo_push),
        .push_dat_i (pkt_addr_i),
        .pop_i      (fifo_pop),
        .pop_dat_o  (fifo_dat),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

    always_comb begin
        idle_mask  = '0;
        done_mask  = '0;
        any_active = 1'b0;
        for (int i = 0; i < NUM_PROCS; i++) begin
            idle_mask[i] = (slot_q[i] == SLOT_IDLE);
            done_mask[i] = (slot_q[i] == SLOT_DONE);
            if (slot_q[i] != SLOT_IDLE) begin
                any_active = 1'b1;
            end
        end
        disp_pick = rr_pick(idle_mask, disp_ptr_q, NUM_PROCS);
        rep_pick  = rr_pick(done_mask, rep_ptr_q, NUM_PROCS);
        disp_fire = !fifo_empty && disp_pick.vld;
        rep_fire  = rep_pick.vld;
    end

    always_comb begin
        disp_ptr_d = disp_fire ? rr_next(disp_pick.idx, NUM_PROCS) : disp_ptr_q;
        rep_ptr_d  = rep_fire  ? rr_next(rep_pick.idx, NUM_PROCS)  : rep_ptr_q;
        ready_en_d = 1'b1;
        done_d     = done_q;
        done_d.vld = rep_fire;
        for (int i = 0; i < NUM_PROCS; i++) begin
            slot_d[i]  = slot_q[i];
            addr_d[i]  = addr_q[i];
            start_d[i] = start_q[i];
            if (rep_fire && rep_pick.idx == PROC_IDX_W'(i)) begin
                done_d.addr = addr_q[i];
                done_d.proc = PROC_IDX_W'(i);
            end
            case (slot_q[i])
                SLOT_IDLE: begin
                    start_d[i] = 1'b0;
                    if (disp_fire && disp_pick.idx == PROC_IDX_W'(i)) begin
                        slot_d[i]  = SLOT_ARM;
                        addr_d[i]  = fifo_dat;
                        start_d[i] = 1'b1;
                    end
                end
                // The proc still shows ready from its previous packet here, so it is not trusted.
                SLOT_ARM: begin
                    slot_d[i]  = SLOT_RUN;
                    start_d[i] = 1'b1;
                end
                SLOT_RUN: begin
                    start_d[i] = 1'b1;
                    if (proc_ready_i[i]) begin
                        slot_d[i]  = SLOT_DONE;
                        start_d[i] = 1'b0;
                    end
                end
                SLOT_DONE: begin
                    start_d[i] = 1'b0;
                    if (rep_fire && rep_pick.idx == PROC_IDX_W'(i)) begin
                        slot_d[i] = SLOT_COOL;
                    end
                end
                SLOT_COOL: begin
                    start_d[i] = 1'b0;
                    slot_d[i]  = SLOT_IDLE;
                end
                default: begin
                    start_d[i] = 1'b0;
                    slot_d[i]  = SLOT_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_PROCS; i++) begin
                slot_q[i] <= SLOT_IDLE;
                addr_q[i] <= '0;
            end
            start_q    <= '0;
            disp_ptr_q <= '0;
            rep_ptr_q  <= '0;
            done_q     <= '0;
            ready_en_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_PROCS; i++) begin
                slot_q[i] <= slot_d[i];
                addr_q[i] <= addr_d[i];
            end
            start_q    <= start_d;
            disp_ptr_q <= disp_ptr_d;
            rep_ptr_q  <= rep_ptr_d;
            done_q     <= done_d;
            ready_en_q <= ready_en_d;
        end
    end

    always_comb begin
        pkt_addr_o = '0;
        for (int i = 0; i < NUM_PROCS; i++) begin
            pkt_addr_o[i*ADDR_W +: ADDR_W] = addr_q[i];
        end
    end

    assign start_o      = start_q;
    assign done_valid_o = done_q.vld;
    assign done_addr_o  = done_q.addr;
    assign done_proc_o  = done_q.proc;
    assign busy_o       = !fifo_empty || any_active;

endmodule
